// File: rtl/mux4_rr_arb.sv
// Four-channel round-robin packet arbiter feeding a single registered output slot.
// A channel that starts a multi-beat packet holds the grant until its last beat.
module mux4_rr_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  input  logic [3:0]       in_last,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_last,
  input  logic             out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_next;
  logic [1:0]       lock_ch, lock_next;
  logic [1:0]       ptr, ptr_next;
  logic             slot_free;
  logic             grant_any;
  logic [1:0]       grant_ch;
  logic             in_fire;
  logic [WIDTH-1:0] sel_data;

  assign slot_free = !out_valid || out_ready;

  // Lowest offset from ptr wins, so the loop runs downward and lets nearer hits overwrite.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    grant_any = 1'b0;
    grant_ch  = ptr;
    if (state == LOCKED) begin
      grant_any = 1'b1;
      grant_ch  = lock_ch;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        idx = ptr + 2'(k);
        if (in_valid[idx]) begin
          grant_any = 1'b1;
          grant_ch  = idx;
        end
      end
    end
  end

  assign in_ready = (grant_any && slot_free && !rst) ? (4'b0001 << grant_ch) : 4'b0000;
  assign in_fire  = |(in_valid & in_ready);

  always_comb begin
    case (grant_ch)
      2'd0:    sel_data = in_data0;
      2'd1:    sel_data = in_data1;
      2'd2:    sel_data = in_data2;
      default: sel_data = in_data3;
    endcase
  end

  always_comb begin
    state_next = state;
    lock_next  = lock_ch;
    ptr_next   = ptr;
    if (in_fire) begin
      if (in_last[grant_ch]) begin
        state_next = IDLE;
        ptr_next   = grant_ch + 2'd1;
      end else begin
        state_next = LOCKED;
        lock_next  = grant_ch;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= 2'd0;
      ptr     <= 2'd0;
    end else begin
      state   <= state_next;
      lock_ch <= lock_next;
      ptr     <= ptr_next;
    end
  end

  // A new beat overwrites the slot even while the old one leaves, so no bubble appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_ch;
      out_last  <= in_last[grant_ch];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
